// File: rtl/bcd_to_bin_if.sv
// Start/done handshake bundle for the BCD-to-binary converter.
// The requester drives init and the BCD operand; the converter returns result and done.
interface bcd_to_bin_if #(
    parameter int DIGITS   = 5,
    parameter int RESULT_W = 33
);
    logic                  init;
    logic [4*DIGITS-1:0]   A;
    logic [RESULT_W-1:0]   result;
    logic                  done;

    modport master (output init, A, input result, done);
    modport slave  (input init, A, output result, done);
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter using reverse double-dabble,
// one shift/adjust step per clock and one step per BCD input bit.
//
// state | meaning
// IDLE  | waiting for init; operand captured on the start edge
// SHIFT | one shift-right plus digit adjust per clock, 4*DIGITS steps
// DONE  | single cycle with done high; result already updated
module bcd_to_bin #(
    parameter int DIGITS   = 5,
    parameter int RESULT_W = 33
) (
    input  logic          clk,
    input  logic          rst,
    bcd_to_bin_if.slave   bus
);
    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_nx;
    logic [W-1:0]         bcd_q;
    logic [W-1:0]         bin_q;
    logic [W-1:0]         bcd_nx;
    logic [W-1:0]         bin_nx;
    logic [W-1:0]         bcd_sh;
    logic [2*W-1:0]       shifted;
    logic [CNT_W-1:0]     cnt_q;
    logic [RESULT_W-1:0]  result_q;
    logic                 last_step;

    assign last_step = (cnt_q == CNT_W'(W - 1));

    // One algorithm step: shift {bcd, bin} right, then pull every digit >= 8 back by 3.
    always_comb begin
        shifted = {bcd_q, bin_q} >> 1;
        bcd_sh  = shifted[2*W-1:W];
        bin_nx  = shifted[W-1:0];
        bcd_nx  = bcd_sh;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sh[4*i+3]) begin
                bcd_nx[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        state_nx = state_q;
        bus.done = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.init) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd_q    <= '0;
            bin_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.init) begin
                        bcd_q <= bus.A;
                        bin_q <= '0;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_nx;
                    bin_q <= bin_nx;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Result is published on the edge that enters DONE and held until the next one.
                    if (last_step) begin
                        result_q <= RESULT_W'(bin_nx);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.result = result_q;
endmodule

// File: tb/tb_bcd_to_bin.sv
// Randomized and directed bench for bcd_to_bin: a cycle-level reference model
// computes expected done/result from decimal arithmetic and is compared every cycle.
module tb_bcd_to_bin;
    localparam int DIGITS   = 5;
    localparam int RESULT_W = 33;
    localparam int W        = 4 * DIGITS;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bcd_to_bin_if #(.DIGITS(DIGITS), .RESULT_W(RESULT_W)) bus ();

    bcd_to_bin #(.DIGITS(DIGITS), .RESULT_W(RESULT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RESULT_W-1:0] bcd_value(input logic [W-1:0] a);
        logic [RESULT_W-1:0] v;
        v = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v = v * 10 + RESULT_W'(a[4*i +: 4]);
        end
        return v;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] a;
        for (int i = 0; i < DIGITS; i++) begin
            a[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return a;
    endfunction

    task automatic chk(input string name, input logic [RESULT_W-1:0] act, input logic [RESULT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: idle / busy for 4*DIGITS steps / one-cycle done.
    int                  m_rem;
    logic                m_done;
    logic [RESULT_W-1:0] m_res;
    logic [RESULT_W-1:0] m_cap;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_cap  <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_done <= 1'b1;
                m_res  <= m_cap;
            end
        end else if (bus.init) begin
            m_cap <= bcd_value(bus.A);
            m_rem <= W;
        end
    end

    always @(negedge clk) begin
        chk("done_vs_model", {{(RESULT_W-1){1'b0}}, bus.done}, {{(RESULT_W-1){1'b0}}, m_done});
        chk("result_vs_model", bus.result, m_res);
    end

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic convert(input string name, input logic [W-1:0] a, input int hold,
                           input logic [RESULT_W-1:0] exp);
        int n;
        @(negedge clk);
        bus.A    = a;
        bus.init = 1'b1;
        repeat (hold) @(negedge clk);
        bus.init = 1'b0;
        bus.A    = rand_bcd();
        wait_done(n);
        chk({name, "_latency"}, RESULT_W'(n), RESULT_W'(21 - hold));
        chk({name, "_result"}, bus.result, exp);
        chk({name, "_model"}, m_res, exp);
        @(negedge clk);
        chk({name, "_done_width"}, {{(RESULT_W-1){1'b0}}, bus.done}, '0);
        chk({name, "_hold"}, bus.result, exp);
    endtask

    initial begin
        int n;
        int pulses;
        logic [W-1:0] a;
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        bus.init = 1'b0;
        bus.A    = '0;
        repeat (3) @(negedge clk);
        chk("reset_result", bus.result, '0);
        chk("reset_done", {{(RESULT_W-1){1'b0}}, bus.done}, '0);
        rst = 1'b1;

        convert("c35789", 20'h35789, 2, 33'h0_0000_8BCD);
        convert("c99999", 20'h99999, 1, 33'h1869F);
        convert("c00000", 20'h00000, 1, 33'h0);
        convert("c00001", 20'h00001, 1, 33'h1);
        convert("c10000", 20'h10000, 1, 33'h2710);

        // Operand change and init pulse while shifting must not disturb the conversion.
        @(negedge clk);
        bus.A    = 20'h12345;
        bus.init = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        repeat (5) @(negedge clk);
        bus.A    = 20'h99999;
        bus.init = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        wait_done(n);
        chk("midshift_result", bus.result, 33'h3039);
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        chk("midshift_extra_pulses", RESULT_W'(pulses), '0);

        // Asynchronous reset around step 10.
        @(negedge clk);
        bus.A    = 20'h54321;
        bus.init = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_result", bus.result, '0);
        chk("abort_done", {{(RESULT_W-1){1'b0}}, bus.done}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        convert("after_abort", 20'h00777, 1, 33'h309);

        // Level-held init gives back-to-back conversions every 22 cycles.
        @(negedge clk);
        bus.A    = 20'h00042;
        bus.init = 1'b1;
        wait_done(n);
        chk("b2b_first", bus.result, 33'h2A);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (bus.done !== 1'b1 && n < 60);
            chk("b2b_period", RESULT_W'(n), RESULT_W'(22));
            chk("b2b_result", bus.result, 33'h2A);
        end
        bus.init = 1'b0;
        repeat (25) @(negedge clk);

        for (int k = 0; k < 25; k++) begin
            a = rand_bcd();
            convert("random", a, int'($urandom_range(1, 3)), bcd_value(a));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Sequential converter from a packed multi-digit BCD word to an unsigned binary integer.
- Uses the reverse double-dabble algorithm: one shift/adjust step per clock, one step per input bit.
- Sits in the calculator datapath between BCD keypad/display-side values and the binary arithmetic core.
- Start/done handshake; result is zero-extended to a fixed output width.

Parameters:
- DIGITS, 5, number of BCD digits in A; A width = 4*DIGITS.
- RESULT_W, 33, width of result; must be >= the bits needed for 10^DIGITS - 1 (17 for DIGITS=5).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- init  input  1  start request; sampled only in IDLE.
- A  input  4*DIGITS (20)  packed BCD operand; A[3:0] is the least significant digit.
- result  output  RESULT_W (33)  binary value of A, zero-extended.
- done  output  1  one-cycle pulse marking result valid.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; result=0; done=0; internal BCD/binary shift registers and step counter cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - done=0.
  - On a rising edge with init=1: load A into a 4*DIGITS-bit BCD register, clear a 4*DIGITS-bit binary register, clear the counter, go to SHIFT.
  - A is captured only at this edge; later changes to A do not affect the conversion in progress.
- SHIFT, one step per clock:
  - Shift the concatenation {bcd, bin} right by 1; the bcd LSB enters the bin MSB.
  - After the shift, subtract 3 from every 4-bit bcd digit whose value is >= 8.
  - Increment the counter.
  - After step 4*DIGITS (20), go to DONE; bin now holds the binary value.
- DONE (lasts exactly one cycle):
  - done=1; result = zero-extended bin.
  - Next edge returns to IDLE.
- Latency: init captured at edge k. Steps occur on edges k+1 .. k+20. The edge-k+20 transition enters DONE, so done is high from edge k+20 until edge k+21, with result valid from edge k+20.
- result holds its value until the next DONE or reset. It does not change during a later conversion until that conversion's DONE.
- init is ignored in SHIFT and DONE; no restart, no abort.
- If init is still high when IDLE is re-entered, a new conversion starts at that edge (level-sensitive start).
- Invalid BCD digits (values 10..15): no error flag. The output is the deterministic result of the same algorithm, and its value is unspecified.
- Reset asserted mid-conversion aborts immediately to the reset state; no done pulse.
- Arithmetic: unsigned only. Maximum result for DIGITS=5 is 99999 = 0x1869F. Upper result bits are always 0.

Test Plan:
- Reset low, then init=1 held 2 cycles with A=0x35789 -> done pulses exactly one cycle, 20 cycles after the capture edge; result=0x0_0000_8BCD (35789).
- A=0x99999 -> result=0x1869F. A=0x00000 -> result=0, and done still pulses.
- A=0x00001 -> result=1. A=0x10000 -> result=0x2710.
- Change A and pulse init while in SHIFT -> no effect; result matches the originally captured A, and there is a single done pulse.
- Drive rst low mid-conversion (step ~10) -> result=0 and done=0 immediately; after release, a fresh init converts correctly.
- Keep init high continuously with A=0x00042 -> back-to-back conversions, done pulses every 22 cycles, result=0x2A.
